skylark_mem_arbiter: RTL and testbench

//  Shares one single-port unified SRAM between the core's instruction-fetch port, the core's data

---
 rtl/skylark_mem_pkg.sv | 10 +
 rtl/skylark_arb_prio.sv | 32 +++
 rtl/skylark_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_skylark_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/skylark_mem_pkg.sv
// Shared types and constants for the skylark memory arbiter.
package skylark_mem_pkg;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

  typedef enum logic [1:0] {REQ_NONE, REQ_IF, REQ_D, REQ_LD} req_id_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/skylark_arb_prio.sv
// Combinational priority select: ld > d > if, unless fetch is starving.
module skylark_arb_prio
  import skylark_mem_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       ld_req,
  input  logic       starve,
  output req_id_t    winner,
  output logic [2:0] gnt_oh
);

  always_comb begin
    winner = REQ_NONE;
    if (if_req && starve) winner = REQ_IF;
    else if (ld_req)      winner = REQ_LD;
    else if (d_req)       winner = REQ_D;
    else if (if_req)      winner = REQ_IF;
  end

  // One-hot bit order: [0] fetch, [1] data, [2] loader
  always_comb begin
    gnt_oh = 3'b000;
    unique case (winner)
      REQ_IF:  gnt_oh = 3'b001;
      REQ_D:   gnt_oh = 3'b010;
      REQ_LD:  gnt_oh = 3'b100;
      default: gnt_oh = 3'b000;
    endcase
  end

endmodule

// File: rtl/skylark_mem_arbiter.sv
// Single-port SRAM arbiter for fetch, data and loader ports; one read outstanding at a time.
module skylark_mem_arbiter
  import skylark_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_stall
);

  localparam int unsigned LSB   = $clog2(WORD_BYTES);
  localparam int unsigned LAT_W = 3;
  localparam int unsigned STV_W = 4;

  arb_state_t        state_q, state_d;
  req_id_t           id_q;
  req_id_t           winner;
  logic [2:0]        gnt_oh;
  logic [LAT_W-1:0]  lat_q;
  logic [STV_W-1:0]  stv_q;
  logic              starve;
  logic              idle;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{if_addr[LSB-1:0], d_addr[LSB-1:0], ld_addr[LSB-1:0]};

  assign starve = (stv_q == STV_W'(MAX_WAIT));
  // Gating with reset keeps the combinational grants quiet while reset is held
  assign idle   = (state_q == ARB_IDLE) && !reset;

  skylark_arb_prio u_prio (
    .if_req (if_req),
    .d_req  (d_req),
    .ld_req (ld_req),
    .starve (starve),
    .winner (winner),
    .gnt_oh (gnt_oh)
  );

  assign if_gnt = idle & gnt_oh[0];
  assign d_gnt  = idle & gnt_oh[1];
  assign ld_gnt = idle & gnt_oh[2];

  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (idle) begin
      unique case (winner)
        REQ_IF: begin
          mem_en   = 1'b1;
          mem_addr = if_addr[ADDR_W-1:LSB];
          state_d  = ARB_WAIT;
        end
        REQ_D: begin
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr[ADDR_W-1:LSB];
          mem_wdata = d_wdata;
          if (!d_we) state_d = ARB_WAIT;
        end
        REQ_LD: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr[ADDR_W-1:LSB];
          mem_wdata = ld_wdata;
        end
        default: ;
      endcase
    end else if (state_q == ARB_WAIT && lat_q == LAT_W'(1)) begin
      state_d = ARB_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      id_q        <= REQ_NONE;
      lat_q       <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (state_q == ARB_IDLE && state_d == ARB_WAIT) begin
        lat_q <= LAT_W'(MEM_LATENCY);
        id_q  <= winner;
      end else if (state_q == ARB_WAIT) begin
        lat_q <= lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          if (id_q == REQ_IF) begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= mem_rdata;
          end else begin
            d_rvalid_q <= 1'b1;
            d_rdata_q  <= mem_rdata;
          end
        end
      end
    end
  end

  // Starvation counter only advances while arbitration is actually happening
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stv_q <= '0;
    end else if (!if_req || if_gnt) begin
      stv_q <= '0;
    end else if (state_q == ARB_IDLE && !starve) begin
      stv_q <= stv_q + STV_W'(1);
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign d_rvalid   = d_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign core_stall = (if_req & ~if_gnt) | (d_req & ~d_gnt) | (state_q == ARB_WAIT);

endmodule

// File: tb/tb_skylark_mem_arbiter.sv
// Directed bench for skylark_mem_arbiter: one instance at latency 1, one at latency 3.
module tb_skylark_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // Latency-1 instance
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        ld_req, ld_gnt;
  logic [31:0] ld_addr, ld_wdata;
  logic        mem_en, mem_we, core_stall;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  // Latency-3 instance
  logic        if2_gnt, if2_rvalid, d2_req, d2_gnt, d2_rvalid, ld2_gnt;
  logic [31:0] if2_rdata, d2_addr, d2_rdata;
  logic        mem2_en, mem2_we, core_stall2;
  logic [29:0] mem2_addr;
  logic [31:0] mem2_wdata, mem2_rdata;

  int n_checks = 0;
  int n_errors = 0;

  skylark_mem_arbiter #(.MEM_LATENCY(1), .MAX_WAIT(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .core_stall(core_stall)
  );

  skylark_mem_arbiter #(.MEM_LATENCY(3), .MAX_WAIT(4)) u_dut2 (
    .clk(clk), .reset(reset),
    .if_req(1'b0), .if_addr(32'h0), .if_gnt(if2_gnt), .if_rvalid(if2_rvalid),
    .if_rdata(if2_rdata),
    .d_req(d2_req), .d_we(1'b0), .d_addr(d2_addr), .d_wdata(32'h0), .d_gnt(d2_gnt),
    .d_rvalid(d2_rvalid), .d_rdata(d2_rdata),
    .ld_req(1'b0), .ld_addr(32'h0), .ld_wdata(32'h0), .ld_gnt(ld2_gnt),
    .mem_en(mem2_en), .mem_we(mem2_we), .mem_addr(mem2_addr), .mem_wdata(mem2_wdata),
    .mem_rdata(mem2_rdata), .core_stall(core_stall2)
  );

  // SRAM model: word i resets to 0xA500_0000 | i
  logic [31:0] mem [64];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
    pipe1    <= (mem_en && !mem_we) ? mem[mem_addr[5:0]] : 32'h0;
    pipe3[0] <= (mem2_en && !mem2_we) ? mem[mem2_addr[5:0]] : 32'h0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata  = pipe1;
  assign mem2_rdata = pipe3[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    ld_req = 0; ld_addr = 0; ld_wdata = 0; d2_req = 0; d2_addr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_gnt", 32'({if_gnt, d_gnt, ld_gnt}), 0);
    check_eq("rst_mem_en", 32'({mem_en, mem_we}), 0);
    check_eq("rst_rvalid", 32'({if_rvalid, d_rvalid}), 0);
    check_eq("rst_rdata", if_rdata | d_rdata, 0);
    check_eq("rst_stall", 32'(core_stall), 0);
    tick();

    // 1: fetch read, latency 1
    if_req = 1; if_addr = 32'h10; #1;
    check_eq("t1_if_gnt", 32'(if_gnt), 1);
    check_eq("t1_mem_en", 32'({mem_en, mem_we}), 2);
    check_eq("t1_mem_addr", 32'(mem_addr), 4);
    tick(); if_req = 0; #1;
    check_eq("t1_wait_rvalid", 32'(if_rvalid), 0);
    check_eq("t1_wait_stall", 32'(core_stall), 1);
    tick(); #1;
    check_eq("t1_rvalid", 32'(if_rvalid), 1);
    check_eq("t1_rdata", if_rdata, 32'hA500_0004);
    tick(); #1;
    check_eq("t1_rvalid_pulse", 32'(if_rvalid), 0);

    // 2: three back-to-back writes, then read back
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t2_wr_gnt", 32'({d_gnt, mem_en, mem_we}), 7);
      check_eq("t2_wr_addr", 32'(mem_addr), 8);
      check_eq("t2_wr_data", mem_wdata, 32'hDEADBEEF);
      tick();
    end
    d_we = 0; #1;
    check_eq("t2_rd_gnt", 32'({d_gnt, mem_we}), 2);
    tick(); d_req = 0; #1;
    check_eq("t2_rd_wait", 32'(d_rvalid), 0);
    tick(); #1;
    check_eq("t2_rd_rvalid", 32'(d_rvalid), 1);
    check_eq("t2_rd_data", d_rdata, 32'hDEADBEEF);
    tick();

    // 3: priority and starvation, gnt vector is {if, d, ld}
    ld_req = 1; ld_addr = 32'h40; ld_wdata = 32'h11;
    d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'h22;
    if_req = 1; if_addr = 32'h0; #1;
    check_eq("t3_c0", 32'({if_gnt, d_gnt, ld_gnt}), 1);
    check_eq("t3_c0_stall", 32'(core_stall), 1);
    tick(); ld_req = 0; #1;
    check_eq("t3_c1", 32'({if_gnt, d_gnt, ld_gnt}), 2);
    tick(); ld_req = 1; #1;
    check_eq("t3_c2", 32'({if_gnt, d_gnt, ld_gnt}), 1);
    tick(); #1;
    check_eq("t3_c3", 32'({if_gnt, d_gnt, ld_gnt}), 1);
    tick(); #1;
    check_eq("t3_c4_starve", 32'({if_gnt, d_gnt, ld_gnt}), 4);
    check_eq("t3_c4_mem", 32'({mem_en, mem_we}), 2);
    check_eq("t3_c4_addr", 32'(mem_addr), 0);
    tick(); if_req = 0; #1;
    check_eq("t3_wait_nogrant", 32'({if_gnt, d_gnt, ld_gnt, mem_en}), 0);
    check_eq("t3_wait_stall", 32'(core_stall), 1);
    tick(); #1;
    check_eq("t3_rvalid", 32'(if_rvalid), 1);
    check_eq("t3_rdata", if_rdata, 32'hA500_0000);
    check_eq("t3_rearb", 32'(ld_gnt), 1);
    tick(); ld_req = 0; d_req = 0; d_we = 0;
    tick();

    // 6: fetch dropped before grant while loader busy
    ld_req = 1; if_req = 1; if_addr = 32'h0C; #1;
    check_eq("t6_e0", 32'({if_gnt, ld_gnt}), 1);
    tick(); #1;
    check_eq("t6_e1", 32'(if_gnt), 0);
    tick(); if_req = 0; #1;
    check_eq("t6_drop_mem", 32'({if_gnt, mem_en, mem_we}), 3);
    tick(); if_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t6_denied", 32'({if_gnt, ld_gnt}), 1);
      tick();
    end
    #1;
    check_eq("t6_if_wins", 32'({if_gnt, ld_gnt}), 2);
    check_eq("t6_if_addr", 32'(mem_addr), 3);
    tick(); if_req = 0; ld_req = 0;
    tick(); #1;
    check_eq("t6_rvalid", 32'(if_rvalid), 1);
    check_eq("t6_rdata", if_rdata, 32'hA500_0003);
    tick();

    // 5: asynchronous reset in the middle of a read
    d_req = 1; d_we = 0; d_addr = 32'h8; if_req = 1; if_addr = 32'h0; #1;
    check_eq("t5_gnt", 32'(d_gnt), 1);
    tick(); d_req = 0; #1;
    reset = 1'b1; #1;
    check_eq("t5_rst_outs", 32'({if_gnt, d_gnt, ld_gnt, mem_en, mem_we, d_rvalid, if_rvalid}), 0);
    check_eq("t5_rst_rdata", d_rdata | if_rdata, 0);
    tick(); if_req = 0; reset = 1'b0; #1;
    check_eq("t5_no_rvalid_a", 32'({d_rvalid, if_rvalid}), 0);
    tick(); #1;
    check_eq("t5_no_rvalid_b", 32'({d_rvalid, if_rvalid, core_stall}), 0);
    tick();

    // 4: latency-3 data read on the second instance
    d2_req = 1; d2_addr = 32'h10; #1;
    check_eq("t4_gnt", 32'({d2_gnt, mem2_en, core_stall2}), 6);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_wait", 32'({d2_gnt, d2_rvalid, core_stall2}), 1);
      tick();
    end
    #1;
    check_eq("t4_rvalid", 32'(d2_rvalid), 1);
    check_eq("t4_rdata", d2_rdata, 32'hA500_0004);
    check_eq("t4_rearb", 32'(d2_gnt), 1);
    tick(); d2_req = 0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
